// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: frame and counter widths,
// FSM state encoding, common keyboard command bytes and the parity helper.
package ps2_host_tx_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FRAME_W  = 10;   // data + parity + stop
    localparam int unsigned BITCNT_W = 4;
    localparam int unsigned CNT_W    = 20;   // shared inhibit / timeout counter

    localparam logic [DATA_W-1:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [DATA_W-1:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [DATA_W-1:0] PS2_ACK         = 8'hFA;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RTS      = 3'd2,
        ST_SEND     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAITIDLE = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } state_t;

    // Odd parity bit: makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the asynchronous PS/2 clock and data lines into clk and flags
// falling edges of the PS/2 clock. Shared with the PS/2 receiver.
// Ports:
//   clk, clrn      system clock, async active-low reset
//   ps2_clk        raw PS/2 clock line
//   ps2_data       raw PS/2 data line
//   clk_s, data_s  synchronized line levels (aligned with each other)
//   clk_fall_c     one-cycle flag: synced clock was high, is now low
module ps2_sync_edge (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall_c
);

    logic [2:0] clk_sr;
    logic [1:0] data_sr;

    // Idle PS/2 lines are high, so reset the chains to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sr  <= 3'b111;
            data_sr <= 2'b11;
        end else begin
            clk_sr  <= {clk_sr[1:0], ps2_clk};
            data_sr <= {data_sr[0], ps2_data};
        end
    end

    assign clk_s      = clk_sr[1];
    assign data_s     = data_sr[1];
    assign clk_fall_c = clk_sr[2] & ~clk_sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte: inhibits the bus,
// issues request-to-send, shifts data/parity/stop on device clock falls,
// checks the device ACK and times out if the device stalls.
// Ports:
//   clk, clrn               system clock, async active-low reset
//   tx_data, tx_valid       command byte and request; accepted when tx_ready
//   tx_ready                high only while idle
//   ps2_clk, ps2_data       raw PS/2 line levels
//   ps2_clk_oe, ps2_data_oe 1 = pull the corresponding line low
//   busy                    high from accept until back to idle
//   done, err               one-cycle completion / failure pulses
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              ps2_clk_oe,
    output logic              ps2_data_oe,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0]    INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BITCNT_W-1:0] LAST_FALL = BITCNT_W'(FRAME_W - 1);

    logic clk_s, data_s, clk_fall_c;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fall_c (clk_fall_c)
    );

    state_t               state, state_nxt;
    logic [FRAME_W-1:0]   shreg, shreg_nxt;
    logic [BITCNT_W-1:0]  bitcnt, bitcnt_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 clk_oe_nxt, data_oe_nxt;
    logic                 busy_nxt, done_nxt, err_nxt, ready_nxt;

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            tx_ready    <= 1'b1;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bitcnt      <= bitcnt_nxt;
            cnt         <= cnt_nxt;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
            tx_ready    <= ready_nxt;
        end
    end

    // Next state, datapath and next output values.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bitcnt_nxt  = bitcnt;
        cnt_nxt     = cnt;
        data_oe_nxt = ps2_data_oe;

        case (state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_nxt  = {1'b1, odd_parity(tx_data), tx_data};
                    bitcnt_nxt = '0;
                    cnt_nxt    = '0;
                    state_nxt  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_nxt = ST_RTS;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RTS: begin
                cnt_nxt   = '0;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                // Timeout is checked first so it wins over a same-cycle fall.
                if (cnt == TO_LAST) begin
                    state_nxt = ST_ERR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (clk_fall_c) begin
                        data_oe_nxt = ~shreg[0];
                        shreg_nxt   = {1'b0, shreg[FRAME_W-1:1]};
                        bitcnt_nxt  = bitcnt + BITCNT_W'(1);
                        if (bitcnt == LAST_FALL) begin
                            state_nxt = ST_ACK;
                        end
                    end
                end
            end
            ST_ACK: begin
                if (cnt == TO_LAST) begin
                    state_nxt = ST_ERR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (clk_fall_c) begin
                        state_nxt = data_s ? ST_ERR : ST_WAITIDLE;
                    end
                end
            end
            ST_WAITIDLE: begin
                if (cnt == TO_LAST) begin
                    state_nxt = ST_ERR;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (clk_s && data_s) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Start bit is driven from RTS until the first fall replaces it.
        if (state_nxt == ST_RTS) begin
            data_oe_nxt = 1'b1;
        end else if (state_nxt inside {ST_IDLE, ST_INHIBIT, ST_DONE, ST_ERR}) begin
            data_oe_nxt = 1'b0;
        end

        clk_oe_nxt = (state_nxt == ST_INHIBIT) || (state_nxt == ST_RTS);
        busy_nxt   = (state_nxt != ST_IDLE);
        ready_nxt  = (state_nxt == ST_IDLE);
        done_nxt   = (state_nxt == ST_DONE);
        err_nxt    = (state_nxt == ST_ERR);
    end

endmodule
